// File: rtl/i2s_pkg.sv
// Shared constants and types for the I2S serializer: frame geometry and the
// bit positions of the clock/slot fields within the free-running frame counter.
package i2s_pkg;

  localparam int unsigned FRAME_CLKS      = 1024;
  localparam int unsigned SLOTS_PER_FRAME = 64;
  localparam int unsigned SLOTS_PER_CH    = 32;

  localparam int unsigned CNT_W    = 10;
  localparam int unsigned MCLK_BIT = 1;
  localparam int unsigned SCLK_BIT = 3;
  localparam int unsigned LRCK_BIT = 9;
  localparam int unsigned SLOT_LSB = 4;
  localparam int unsigned SLOT_W   = LRCK_BIT - SLOT_LSB + 1;

  // Strobes from the clock generator; slot is the slot that begins after this edge.
  typedef struct packed {
    logic              cap;
    logic              fall;
    logic [SLOT_W-1:0] slot;
  } i2s_tick_t;

endpackage

// File: rtl/i2s_clkgen.sv
// Frame counter and codec clock outputs for the I2S serializer. All clocks are
// taken straight from counter flops, so they carry no decode glitches.
module i2s_clkgen
  import i2s_pkg::*;
(
  input  logic      clk_i,
  input  logic      rst_i,
  output logic      mclk_o,
  output logic      sclk_o,
  output logic      lrck_o,
  output i2s_tick_t tick_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign mclk_o = cnt_q[MCLK_BIT];
  assign sclk_o = cnt_q[SCLK_BIT];
  assign lrck_o = cnt_q[LRCK_BIT];

  // fall marks the edge that drops SCLK, i.e. the edge that opens slot tick_o.slot.
  always_comb begin
    tick_o      = '0;
    tick_o.cap  = ~rst_i & (cnt_q == CNT_W'(FRAME_CLKS - 1));
    tick_o.fall = (cnt_q[SLOT_LSB-1:0] == '1);
    tick_o.slot = cnt_d[LRCK_BIT:SLOT_LSB];
  end

endmodule

// File: rtl/i2s_serializer.sv
// I2S stereo serializer: captures L/R samples once per 1024-clk frame and shifts them
// out MSB first. Define I2S_LJ_FORMAT_EN for left-justified instead of Philips I2S.
module i2s_serializer
  import i2s_pkg::*;
#(
  parameter int unsigned SAMPLE_W = 16
) (
  input  logic                clk,
  input  logic                Reset,
  input  logic [SAMPLE_W-1:0] L_data,
  input  logic [SAMPLE_W-1:0] R_data,
  input  logic                mute,
  output logic                sample_ack,
  output logic                dac_MCLK,
  output logic                dac_SCLK,
  output logic                dac_LRCK,
  output logic                dac_SDIN
);

  i2s_tick_t tick;

  i2s_clkgen u_clkgen (
    .clk_i  (clk),
    .rst_i  (Reset),
    .mclk_o (dac_MCLK),
    .sclk_o (dac_SCLK),
    .lrck_o (dac_LRCK),
    .tick_o (tick)
  );

  logic [SAMPLE_W-1:0] shadow_l_q, shadow_l_d;
  logic [SAMPLE_W-1:0] shadow_r_q, shadow_r_d;
  logic                sdin_q, sdin_d;
  logic                slot_bit;
  int unsigned         slot_idx;

  // Bit at distance off below the MSB.
  function automatic logic msb_pick(input logic [SAMPLE_W-1:0] d, input int unsigned off);
    logic [SAMPLE_W-1:0] sh;
    sh = d >> (SAMPLE_W - 1 - off);
    return sh[0];
  endfunction

  always_comb begin
    shadow_l_d = shadow_l_q;
    shadow_r_d = shadow_r_q;
    if (tick.cap) begin
      shadow_l_d = mute ? '0 : L_data;
      shadow_r_d = mute ? '0 : R_data;
    end
  end

  // Selection reads the next-state shadows so a slot opened on the capture edge
  // already sees the new frame.
`ifdef I2S_LJ_FORMAT_EN
  always_comb begin
    slot_idx = 32'(tick.slot);
    slot_bit = 1'b0;
    if (slot_idx < SAMPLE_W) begin
      slot_bit = msb_pick(shadow_l_d, slot_idx);
    end else if (slot_idx >= SLOTS_PER_CH && slot_idx < SLOTS_PER_CH + SAMPLE_W) begin
      slot_bit = msb_pick(shadow_r_d, slot_idx - SLOTS_PER_CH);
    end
  end
`else
  logic carry_q, carry_d;

  // With 32-bit samples the right LSB spills into slot 0 of the following frame.
  always_comb begin
    carry_d  = tick.cap ? shadow_r_q[0] : carry_q;
    slot_idx = 32'(tick.slot);
    slot_bit = 1'b0;
    if (slot_idx >= 1 && slot_idx <= SAMPLE_W) begin
      slot_bit = msb_pick(shadow_l_d, slot_idx - 1);
    end else if (slot_idx >= SLOTS_PER_CH + 1 && slot_idx <= SLOTS_PER_CH + SAMPLE_W) begin
      slot_bit = msb_pick(shadow_r_d, slot_idx - SLOTS_PER_CH - 1);
    end else if (slot_idx == 0 && SAMPLE_W == SLOTS_PER_CH) begin
      slot_bit = carry_d;
    end
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      carry_q <= 1'b0;
    end else begin
      carry_q <= carry_d;
    end
  end
`endif

  always_comb begin
    sdin_d = tick.fall ? slot_bit : sdin_q;
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      shadow_l_q <= '0;
      shadow_r_q <= '0;
      sdin_q     <= 1'b0;
    end else begin
      shadow_l_q <= shadow_l_d;
      shadow_r_q <= shadow_r_d;
      sdin_q     <= sdin_d;
    end
  end

  assign sample_ack = tick.cap;
  assign dac_SDIN   = sdin_q;

endmodule

// File: tb/tb_i2s_serializer.sv
// Self-checking bench for i2s_serializer: a frame-level model predicts every output
// on every clk from the clk count since reset and the sample captured per frame.
module tb_i2s_serializer;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         Reset = 1'b1;
  logic [W-1:0] L_data = '0;
  logic [W-1:0] R_data = '0;
  logic         mute = 1'b0;
  logic         sample_ack, dac_MCLK, dac_SCLK, dac_LRCK, dac_SDIN;

  always #5 clk = ~clk;

  i2s_serializer #(.SAMPLE_W(W)) dut (
    .clk        (clk),
    .Reset      (Reset),
    .L_data     (L_data),
    .R_data     (R_data),
    .mute       (mute),
    .sample_ack (sample_ack),
    .dac_MCLK   (dac_MCLK),
    .dac_SCLK   (dac_SCLK),
    .dac_LRCK   (dac_LRCK),
    .dac_SDIN   (dac_SDIN)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int t       = 0;  // clk edges since Reset was released
  logic [31:0] fr_l = '0, fr_r = '0, prev_r = '0, pend_l = '0, pend_r = '0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cnt=%0d)", tag, got, exp, t % 1024);
    end
  endtask

  function automatic logic bit_of(input logic [31:0] v, input int i);
    logic [31:0] x;
    x = v >> i;
    return x[0];
  endfunction

  function automatic logic exp_sdin(input int s, input logic [31:0] fl, input logic [31:0] fr,
                                    input logic [31:0] pr);
`ifdef I2S_LJ_FORMAT_EN
    if (s < W) return bit_of(fl, W - 1 - s);
    if (s >= 32 && s < 32 + W) return bit_of(fr, W - 1 - (s - 32));
    return 1'b0;
`else
    if (s >= 1 && s <= W) return bit_of(fl, W - s);
    if (s >= 33 && s <= 32 + W) return bit_of(fr, 32 + W - s);
    if (s == 0 && W == 32) return bit_of(pr, 0);
    return 1'b0;
`endif
  endfunction

  // Advance one clk, update the model, then check every output.
  task automatic step();
    bit rst_now;
    bit cap;
    int c;
    rst_now = Reset;
    cap = !rst_now && (t % 1024 == 1023);
    if (cap) begin
      pend_l = mute ? 32'd0 : 32'(L_data);
      pend_r = mute ? 32'd0 : 32'(R_data);
    end
    @(posedge clk);
    if (rst_now) begin
      t = 0; fr_l = '0; fr_r = '0; prev_r = '0;
    end else begin
      t++;
      if (cap) begin
        prev_r = fr_r; fr_l = pend_l; fr_r = pend_r;
      end
    end
    #1;
    c = t % 1024;
    check_eq("sample_ack", 32'(sample_ack), 32'(c == 1023));
    check_eq("dac_MCLK", 32'(dac_MCLK), 32'((c >> 1) & 1));
    check_eq("dac_SCLK", 32'(dac_SCLK), 32'((c >> 3) & 1));
    check_eq("dac_LRCK", 32'(dac_LRCK), 32'((c >> 9) & 1));
    check_eq("dac_SDIN", 32'(dac_SDIN), 32'(exp_sdin(c / 16, fr_l, fr_r, prev_r)));
  endtask

  logic [15:0] pat_l [2] = '{16'hA5A5, 16'h8001};
  logic [15:0] pat_r [2] = '{16'h5A5A, 16'h7FFE};

  initial begin
    Reset = 1'b1;
    repeat (10) step();
    Reset = 1'b0;

    // Fixed patterns, one frame each after the first capture.
    for (int p = 0; p < 2; p++) begin
      L_data = W'(pat_l[p]);
      R_data = W'(pat_r[p]);
      repeat (p == 0 ? 2048 : 1024) step();
    end

    // Random sample per frame.
    repeat (2) begin
      L_data = W'($urandom);
      R_data = W'($urandom);
      repeat (1024) step();
    end

    // Inputs churn every clk; only the capture-cycle value may reach the wire.
    for (int i = 0; i < 2048; i++) begin
      L_data = W'($urandom);
      R_data = W'($urandom);
      step();
    end

    mute   = 1'b1;
    L_data = W'(16'h7FFF);
    R_data = W'($urandom);
    repeat (2048) step();
    mute   = 1'b0;

    // Reset in the middle of a frame carrying live data.
    L_data = W'($urandom);
    R_data = W'($urandom);
    for (int i = 0; i < 2048 && (t % 1024) != 600; i++) step();
    repeat (1100) begin
      if ((t % 1024) == 600) break;
      step();
    end
    Reset = 1'b1;
    repeat (3) step();
    Reset = 1'b0;
    repeat (2048) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
